// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the byte-addressable data memory (data_memory_lsu)
// and its load-alignment helper (dmem_load_align).
//   - access-size encodings (req_size)
//   - controller state enum
//   - helpers for byte-enable masks, store-data replication and lane
//     normalisation of half/word accesses
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_e;

   // Byte-enable mask for a store of the given size at the given lane.
   // Reserved sizes enable nothing.
   function automatic logic [3:0] byte_enable(input logic [1:0] size,
                                              input logic [1:0] lane);
      logic [3:0] be;
      case (size)
         SIZE_BYTE: be = 4'b0001 << lane;
         SIZE_HALF: be = 4'b0011 << lane;
         SIZE_WORD: be = 4'b1111;
         default:   be = 4'b0000;
      endcase
      return be;
   endfunction

   // Store data arrives right-aligned; copy it into every lane so the
   // byte-enable mask alone decides which bytes land in memory.
   function automatic logic [31:0] replicate_wdata(input logic [1:0]  size,
                                                   input logic [31:0] wdata);
      logic [31:0] rep;
      case (size)
         SIZE_BYTE: rep = {4{wdata[7:0]}};
         SIZE_HALF: rep = {2{wdata[15:0]}};
         default:   rep = wdata;
      endcase
      return rep;
   endfunction

   // Halves are forced onto a half boundary and words onto lane 0; the
   // dropped low address bits are either ignored or trapped by the caller.
   function automatic logic [1:0] lane_normalize(input logic [1:0] size,
                                                 input logic [1:0] lane);
      logic [1:0] nl;
      case (size)
         SIZE_HALF: nl = {lane[1], 1'b0};
         SIZE_WORD: nl = 2'b00;
         default:   nl = lane;
      endcase
      return nl;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// -----------------------------------------------------------------------------
// dmem_load_align
// Purely combinational load formatter: picks the addressed byte or half out
// of a 32-bit memory word and sign- or zero-extends it to 32 bits.
// Ports:
//   word        in  32  full memory word
//   lane        in   2  byte lane of the access (already normalised)
//   size        in   2  SIZE_BYTE / SIZE_HALF / SIZE_WORD
//   is_unsigned in   1  zero-extend instead of sign-extend
//   result      out 32  extended load data
// -----------------------------------------------------------------------------
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (lane)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = lane[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      case (size)
         SIZE_BYTE: result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
         SIZE_HALF: result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
         default:   result = word;
      endcase
   end

endmodule

// File: rtl/data_memory_lsu.sv
// -----------------------------------------------------------------------------
// data_memory_lsu
// Byte-addressable data RAM for the MEM stage. Handles RV32I sub-word loads
// and stores with per-byte write lanes, one-cycle registered read latency,
// a base-address window with range checking and a post-reset clearing engine.
//
// Parameters:
//   MEMORY_DEPTH  number of 32-bit words (power of two, >= 4)
//   BASE_ADDR     byte address of word 0 (4-byte aligned)
// Ports:
//   clk           in   1  clock
//   reset         in   1  synchronous active-high reset
//   req_valid     in   1  request present
//   req_ready     out  1  request can be accepted (READY state)
//   req_write     in   1  1 = store, 0 = load
//   req_size      in   2  00 byte, 01 half, 10 word, 11 reserved (error)
//   req_unsigned  in   1  zero-extend byte/half loads
//   req_addr      in  32  byte address
//   req_wdata     in  32  right-aligned store data
//   rsp_valid     out  1  response for the request accepted last edge
//   rsp_rdata     out 32  extended load data, 0 for stores and errors
//   rsp_error     out  1  range / reserved-size / (optional) misalign error
//
// Build option: DATA_MEMORY_LSU_MISALIGN_TRAP_EN makes misaligned half/word
// accesses errors; without it the low address bits are silently dropped.
// -----------------------------------------------------------------------------
module data_memory_lsu
   import dmem_pkg::*;
#(
   parameter int          MEMORY_DEPTH = 64,
   parameter logic [31:0] BASE_ADDR    = 32'h1001_0000
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error
);

   localparam int IDX_W = $clog2(MEMORY_DEPTH);
   localparam int OFF_W = IDX_W + 2;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEMORY_DEPTH - 1);

   // ---------------------------------------------------------------- decode
   logic [31:0]      offset;
   logic             in_range;
   logic [IDX_W-1:0] req_idx;
   logic [1:0]       eff_lane;
   logic             size_err;
   logic             misalign_err;
   logic             req_err;
   logic             accept;

   always_comb begin
      offset   = req_addr - BASE_ADDR;   // wraps, so addresses below BASE fail the range test
      in_range = (offset[31:OFF_W] == '0);
      req_idx  = offset[OFF_W-1:2];
      eff_lane = lane_normalize(req_size, offset[1:0]);
      size_err = (req_size == SIZE_RSVD);
`ifdef DATA_MEMORY_LSU_MISALIGN_TRAP_EN
      misalign_err = ((req_size == SIZE_HALF) && offset[0]) ||
                     ((req_size == SIZE_WORD) && (offset[1:0] != 2'b00));
`else
      misalign_err = 1'b0;
`endif
      req_err = ~in_range | size_err | misalign_err;
      accept  = req_valid & req_ready;
   end

   // ------------------------------------------------------------------- FSM
   state_e           state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;
   logic             init_active;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
               state_d = READY;
            end
         end
         default: begin
            state_d = READY;
         end
      endcase
   end

   // req_ready is a pure function of the state register.
   always_comb begin
      req_ready   = (state_q == READY);
      init_active = (state_q == INIT);
   end

   // ------------------------------------------------------- RAM write port
   // The clearing engine and stores share one write port; they never
   // overlap because no request is accepted during INIT.
   logic [3:0]       wr_en;
   logic [IDX_W-1:0] wr_idx;
   logic [31:0]      wr_data;
   logic             rd_en;

   always_comb begin
      wr_en   = 4'b0000;
      wr_idx  = req_idx;
      wr_data = replicate_wdata(req_size, req_wdata);
      if (init_active) begin
         wr_en   = 4'b1111;
         wr_idx  = cnt_q;
         wr_data = 32'h0;
      end else if (accept && req_write && !req_err) begin
         wr_en = byte_enable(req_size, eff_lane);
      end
      rd_en = accept & ~req_write;
   end

   // ------------------------------------------------------ byte-lane RAMs
   // One narrow RAM per byte lane, each with its own registered read, so
   // per-byte writes map directly onto block RAM write enables.
   logic [31:0] rd_word;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [MEMORY_DEPTH];
         logic [7:0] rd_byte_q;

         always_ff @(posedge clk) begin
            if (wr_en[gi]) begin
               lane_mem[wr_idx] <= wr_data[8*gi +: 8];
            end
            if (rd_en) begin
               rd_byte_q <= lane_mem[req_idx];
            end
         end

         assign rd_word[8*gi +: 8] = rd_byte_q;
      end
   endgenerate

   // ------------------------------------------------------------ response
   logic       rsp_valid_q, rsp_valid_d;
   logic       rsp_error_q, rsp_error_d;
   logic       rsp_load_q,  rsp_load_d;
   logic [1:0] rsp_lane_q,  rsp_lane_d;
   logic [1:0] rsp_size_q,  rsp_size_d;
   logic       rsp_uns_q,   rsp_uns_d;
   logic [31:0] aligned;

   always_comb begin
      rsp_valid_d = accept;
      rsp_error_d = accept & req_err;
      rsp_load_d  = accept & ~req_write & ~req_err;
      rsp_lane_d  = eff_lane;
      rsp_size_d  = req_size;
      rsp_uns_d   = req_unsigned;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_load_q  <= 1'b0;
         rsp_lane_q  <= 2'b00;
         rsp_size_q  <= SIZE_BYTE;
         rsp_uns_q   <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_load_q  <= rsp_load_d;
         rsp_lane_q  <= rsp_lane_d;
         rsp_size_q  <= rsp_size_d;
         rsp_uns_q   <= rsp_uns_d;
      end
   end

   // Alignment runs on registered state only (RAM output word plus captured
   // lane/size/sign), so nothing combinational reaches rsp_* from req_*.
   dmem_load_align u_align (
      .word        (rd_word),
      .lane        (rsp_lane_q),
      .size        (rsp_size_q),
      .is_unsigned (rsp_uns_q),
      .result      (aligned)
   );

   assign rsp_valid = rsp_valid_q;
   assign rsp_error = rsp_error_q;
   assign rsp_rdata = rsp_load_q ? aligned : 32'h0;

endmodule

// File: tb/tb_data_memory_lsu.sv
// -----------------------------------------------------------------------------
// tb_data_memory_lsu
// Scoreboard bench for data_memory_lsu. The driver pushes the expected
// response of every request into a queue; a monitor on the falling edge pops
// and compares whenever rsp_valid is high. Expected values come from a
// byte-array reference model or from fixed constants for directed cases.
// -----------------------------------------------------------------------------
module tb_data_memory_lsu;

   localparam int          DEPTH = 64;
   localparam logic [31:0] BASE  = 32'h1001_0000;
   localparam int          BYTES = 4 * DEPTH;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   data_memory_lsu #(.MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_error    (rsp_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t       sb_q[$];
   logic [7:0] mm [BYTES];
   int         errors = 0;
   int         checks = 0;
   int         cyc    = 0;
   int         txn    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------- model
   function automatic void model_clear();
      for (int i = 0; i < BYTES; i++) mm[i] = 8'h00;
   endfunction

   function automatic void model(input logic wr, input logic [1:0] sz,
                                 input logic uns, input logic [31:0] addr,
                                 input logic [31:0] wd,
                                 output logic [31:0] rd, output logic err);
      logic [31:0] off;
      logic [31:0] v;
      int          n;
      int          a;
      off = addr - BASE;
      err = (off >= 32'(BYTES)) || (sz == 2'b11);
`ifdef DATA_MEMORY_LSU_MISALIGN_TRAP_EN
      if (sz == 2'b01 && off[0]) err = 1'b1;
      if (sz == 2'b10 && off[1:0] != 2'b00) err = 1'b1;
`endif
      rd = 32'h0;
      if (err) return;
      n = 1 << sz;
      a = int'(off) - (int'(off) % n);
      if (wr) begin
         for (int i = 0; i < n; i++) mm[a + i] = wd[8*i +: 8];
      end else begin
         v = 32'h0;
         for (int i = 0; i < n; i++) v = v | (32'(mm[a + i]) << (8 * i));
         if (!uns && n < 4 && v[8*n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
         rd = v;
      end
   endfunction

   // -------------------------------------------------------------- monitor
   always @(negedge clk) begin : mon
      exp_t e;
      if (rsp_valid) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding (rdata=%08h err=%0b)",
                     rsp_rdata, rsp_error);
         end else begin
            e = sb_q.pop_front();
            txn++;
            if (rsp_rdata !== e.rd || rsp_error !== e.err || cyc != e.cyc) begin
               errors++;
               $display("FAIL rsp %0d: got rdata=%08h err=%0b cycle=%0d, want rdata=%08h err=%0b cycle=%0d",
                        txn, rsp_rdata, rsp_error, cyc, e.rd, e.err, e.cyc);
            end else begin
               $display("rsp %0d: rdata=%08h err=%0b ok", txn, rsp_rdata, rsp_error);
            end
         end
      end
   end

   // --------------------------------------------------------------- driver
   task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input bit fixed, input logic [31:0] fix_rd,
                        input logic fix_err);
      int          guard;
      exp_t        e;
      logic [31:0] mrd;
      logic        merr;
      guard = 0;
      while (!req_ready && guard < 1000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: req_ready=%0b after %0d cycles, want 1", req_ready, guard);
         return;
      end
      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      model(wr, sz, uns, addr, wd, mrd, merr);
      e.rd  = fixed ? fix_rd  : mrd;
      e.err = fixed ? fix_err : merr;
      e.cyc = cyc + 1;
      sb_q.push_back(e);
      $display("req %s size=%0d uns=%0b addr=%08h wdata=%08h", wr ? "ST" : "LD", sz, uns, addr, wd);
      @(posedge clk); #1;
   endtask

   task automatic idle();
      req_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic ldx(input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] exp_rd, input logic exp_err);
      issue(1'b0, sz, uns, addr, 32'h0, 1'b1, exp_rd, exp_err);
   endtask

   task automatic st(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
      issue(1'b1, sz, 1'b0, addr, wd, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic check_bit(input string name, input logic act, input logic want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0b, want %0b", name, act, want);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_bit({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      check_bit({tag, "_rsp_error"}, rsp_error, 1'b0);
      check_bit({tag, "_req_ready"}, req_ready, 1'b0);
      checks++;
      if (rsp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL %s_rsp_rdata: got %08h, want 00000000", tag, rsp_rdata);
      end
   endtask

   // Counts edges from reset release until req_ready rises.
   task automatic wait_ready(input string tag);
      int n;
      n = 0;
      while (!req_ready && n < DEPTH + 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n != DEPTH) begin
         errors++;
         $display("FAIL %s_init_len: req_ready rose after %0d edges, want %0d", tag, n, DEPTH);
      end else begin
         $display("%s: req_ready after %0d edges", tag, n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ----------------------------------------------------------- stimulus
   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      int          r;

      reset        = 1'b1;
      req_valid    = 1'b1;   // held high through INIT: must not be accepted
      req_write    = 1'b0;
      req_size     = 2'b10;
      req_unsigned = 1'b0;
      req_addr     = BASE;
      req_wdata    = 32'h0;
      model_clear();

      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      reset = 1'b0;
      wait_ready("init1");
      req_valid = 1'b0;

      // Every word reads back zero after the clearing pass.
      for (int i = 0; i < DEPTH; i++) ldx(BASE + 32'(4 * i), 2'b10, 1'b0, 32'h0, 1'b0);

      // Sub-word stores and sign/zero-extended loads.
      st(BASE + 32'd8, 2'b10, 32'h8899_AABB);
      st(BASE + 32'd9, 2'b00, 32'h0000_0011);
      ldx(BASE + 32'd8,  2'b10, 1'b0, 32'h8899_11BB, 1'b0);
      ldx(BASE + 32'd11, 2'b00, 1'b0, 32'hFFFF_FF88, 1'b0);
      ldx(BASE + 32'd11, 2'b00, 1'b1, 32'h0000_0088, 1'b0);
      ldx(BASE + 32'd10, 2'b01, 1'b0, 32'hFFFF_8899, 1'b0);
      ldx(BASE + 32'd10, 2'b01, 1'b1, 32'h0000_8899, 1'b0);
      idle();

      // Range window edges; out-of-range stores must not alias into memory.
      st(BASE, 2'b10, 32'hCAFE_F00D);
      st(BASE + 32'(BYTES - 4), 2'b10, 32'h1234_5678);
      ldx(BASE + 32'(BYTES), 2'b10, 1'b0, 32'h0, 1'b1);
      ldx(BASE - 32'd4,      2'b10, 1'b0, 32'h0, 1'b1);
      issue(1'b1, 2'b10, 1'b0, BASE + 32'(BYTES), 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b1);
      issue(1'b1, 2'b10, 1'b0, BASE - 32'd4,      32'hDEAD_BEEF, 1'b1, 32'h0, 1'b1);
      ldx(BASE, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0);
      ldx(BASE + 32'(BYTES - 4), 2'b10, 1'b0, 32'h1234_5678, 1'b0);
      ldx(BASE, 2'b11, 1'b0, 32'h0, 1'b1);

      // Misaligned accesses.
`ifdef DATA_MEMORY_LSU_MISALIGN_TRAP_EN
      ldx(BASE + 32'd2, 2'b10, 1'b0, 32'h0, 1'b1);
      ldx(BASE + 32'd1, 2'b01, 1'b0, 32'h0, 1'b1);
`else
      ldx(BASE + 32'd2, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0);
      ldx(BASE + 32'd1, 2'b01, 1'b0, 32'hFFFF_F00D, 1'b0);
`endif
      idle();

      // Randomised traffic against the model.
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle();
         end else begin
            r = $urandom_range(0, 9);
            if (r < 8)       a = BASE + 32'($urandom_range(0, BYTES - 1));
            else if (r == 8) a = ($urandom_range(0, 1) == 0) ? BASE + 32'(BYTES) + 32'($urandom_range(0, 15))
                                                              : BASE - 32'd1 - 32'($urandom_range(0, 15));
            else             a = $urandom;
            r  = $urandom_range(0, 7);
            sz = (r < 7) ? 2'(r % 3) : 2'b11;
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
                  1'b0, 32'h0, 1'b0);
         end
      end
      idle();

      // Back-to-back store/load, then reset during the load's response cycle.
      st(BASE + 32'd20, 2'b10, 32'hA5A5_5A5A);
      ldx(BASE + 32'd20, 2'b10, 1'b0, 32'hA5A5_5A5A, 1'b0);
      req_valid = 1'b0;
      reset     = 1'b1;
      @(posedge clk); #1;
      check_idle_outputs("midreset");
      reset     = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b0;
      model_clear();
      wait_ready("init2");
      req_valid = 1'b0;
      ldx(BASE + 32'd20, 2'b10, 1'b0, 32'h0, 1'b0);
      ldx(BASE + 32'd8,  2'b10, 1'b0, 32'h0, 1'b0);
      ldx(BASE,          2'b10, 1'b0, 32'h0, 1'b0);
      ldx(BASE + 32'(BYTES - 4), 2'b10, 1'b0, 32'h0, 1'b0);

      repeat (3) idle();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: %0d responses never arrived, want 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
